// File: rtl/shiftreg_seq_pkg.sv
// -----------------------------------------------------------------------------
// shiftreg_seq_pkg
// Shared definitions for the TMIIa configuration shift-register sequencer.
//   seq_state_t : sequencer state encoding
//   eff_len()   : maps the requested length onto the number of bits actually
//                 shifted (0 or anything above the register width selects the
//                 full register width)
// -----------------------------------------------------------------------------
package shiftreg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_LOAD,
      ST_DONE
   } seq_state_t;

   function automatic int eff_len(input int req_len, input int max_len);
      if (req_len == 0 || req_len > max_len) begin
         return max_len;
      end
      return req_len;
   endfunction

endpackage

// File: rtl/shiftreg_tick_gen.sv
// -----------------------------------------------------------------------------
// shiftreg_tick_gen
// Prescaler for the shift-clock sequencer. Counts clk_in cycles and asserts
// tick on the last cycle of every half-period of 2**div cycles, then wraps.
// With div = 0 tick is high every cycle.
// Ports:
//   clk_in : reference clock
//   rst    : asynchronous active-low reset
//   clear  : restart the half-period (count returns to 0 on the next edge)
//   div    : half-period exponent
//   tick   : last cycle of the current half-period
// -----------------------------------------------------------------------------
module shiftreg_tick_gen #(
   parameter int DIV_WIDTH   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] limit;

   always_comb begin
      limit = (COUNT_WIDTH'(1) << div) - COUNT_WIDTH'(1);
   end

   assign tick = (count == limit);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shiftreg_seq_ctrl
// Sequencer for the TMIIa configuration shift register. Produces a registered
// shift clock (half-period 2**div clk_in cycles), shifts a programmable-length
// word out MSB-first, captures the chip's serial readback on the same
// transaction and pulses a load strobe at the end.
// Ports:
//   clk_in  : reference clock
//   rst     : asynchronous active-low reset
//   start   : transaction request, only honoured when not busy
//   div     : half-period exponent, latched at accept
//   len     : bits to shift (0 or > SR_WIDTH means SR_WIDTH), latched at accept
//   wr_data : write word, bit L-1 shifted first, latched at accept
//   rd_data : captured readback, right-aligned, first sampled bit at bit L-1
//   busy    : high from the accept edge until done
//   done    : one-cycle completion pulse
//   sr_clk  : shift clock to chip
//   sr_din  : serial data to chip
//   sr_dout : serial readback from chip (clk_in domain)
//   sr_load : latch strobe to chip
// -----------------------------------------------------------------------------
module shiftreg_seq_ctrl
   import shiftreg_seq_pkg::*;
#(
   parameter int SR_WIDTH    = 32,
   parameter int LEN_WIDTH   = 6,
   parameter int DIV_WIDTH   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic [SR_WIDTH-1:0]  wr_data,
   output logic [SR_WIDTH-1:0]  rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 sr_clk,
   output logic                 sr_din,
   input  logic                 sr_dout,
   output logic                 sr_load
);

   seq_state_t           state;
   logic [DIV_WIDTH-1:0] div_q;
   logic [LEN_WIDTH-1:0] bits_left;
   logic [LEN_WIDTH-1:0] len_eff;
   logic [SR_WIDTH-1:0]  wr_aligned;
   logic [SR_WIDTH-1:0]  wr_q;
   logic [SR_WIDTH-1:0]  cap;
   logic                 accept;
   logic                 tick;

   // The write word is left-aligned so bit L-1 sits at the MSB; every later
   // bit is then simply the MSB of a left-shifting register.
   always_comb begin
      len_eff    = LEN_WIDTH'(eff_len(int'(len), SR_WIDTH));
      wr_aligned = wr_data << (SR_WIDTH - int'(len_eff));
   end

   // DONE accepts a new request like IDLE, so a held start re-launches on the
   // edge that ends the done pulse.
   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

   shiftreg_tick_gen #(
      .DIV_WIDTH   (DIV_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_tick_gen (
      .clk_in (clk_in),
      .rst    (rst),
      .clear  (accept),
      .div    (div_q),
      .tick   (tick)
   );

   // Data path: pending write bits and readback capture. Both are fully
   // (re)initialised at accept, so they carry no reset.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         wr_q <= wr_aligned << 1;
         cap  <= '0;
      end else if (tick && (state == ST_HIGH)) begin
         // Readback is sampled at the end of the high phase, just before the
         // falling edge of sr_clk.
         cap  <= {cap[SR_WIDTH-2:0], sr_dout};
         wr_q <= wr_q << 1;
      end
   end

   // Control FSM with registered pin and handshake outputs.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         div_q     <= '0;
         bits_left <= '0;
         sr_clk    <= 1'b0;
         sr_din    <= 1'b0;
         sr_load   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_data   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (accept) begin
                  div_q     <= div;
                  bits_left <= len_eff;
                  sr_din    <= wr_aligned[SR_WIDTH-1];
                  busy      <= 1'b1;
                  state     <= ST_SETUP;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_SETUP: begin
               if (tick) begin
                  sr_clk <= 1'b1;
                  state  <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               if (tick) begin
                  sr_clk    <= 1'b0;
                  bits_left <= bits_left - LEN_WIDTH'(1);
                  // After the last bit the data line holds its value.
                  if (bits_left != LEN_WIDTH'(1)) begin
                     sr_din <= wr_q[SR_WIDTH-1];
                  end
                  state <= ST_LOW;
               end
            end

            ST_LOW: begin
               if (tick) begin
                  if (bits_left == '0) begin
                     sr_load <= 1'b1;
                     state   <= ST_LOAD;
                  end else begin
                     sr_clk <= 1'b1;
                     state  <= ST_HIGH;
                  end
               end
            end

            ST_LOAD: begin
               if (tick) begin
                  sr_load <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  rd_data <= cap;
                  state   <= ST_DONE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_seq_ctrl
// Self-checking bench for shiftreg_seq_ctrl. The reference model describes each
// transaction as a timeline of half-period phases (SETUP, L high/low pairs,
// LOAD) and derives the expected pin values and readback word from it.
// -----------------------------------------------------------------------------
module tb_shiftreg_seq_ctrl;

   logic        clk_in;
   logic        rst;
   logic        start;
   logic [3:0]  div;
   logic [5:0]  len;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        sr_clk;
   logic        sr_din;
   logic        sr_dout;
   logic        sr_load;

   logic        loop_mode;
   logic        dout_drv;
   logic [31:0] prev_rd;
   int          checks;
   int          errors;

   assign sr_dout = loop_mode ? sr_din : dout_drv;

   shiftreg_seq_ctrl dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .start   (start),
      .div     (div),
      .len     (len),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .sr_clk  (sr_clk),
      .sr_din  (sr_din),
      .sr_dout (sr_dout),
      .sr_load (sr_load)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " sr_clk"},  32'(sr_clk),  32'd0);
      chk({tag, " sr_din"},  32'(sr_din),  32'd0);
      chk({tag, " sr_load"}, 32'(sr_load), 32'd0);
      chk({tag, " busy"},    32'(busy),    32'd0);
      chk({tag, " done"},    32'(done),    32'd0);
      chk({tag, " rd_data"}, rd_data,      32'd0);
   endtask

   // mode: 0 = random readback, 1 = sr_dout looped from sr_din, 2 = sr_dout tied 1
   // poke_c: cycle after accept at which a conflicting start is raised (-1 = none)
   // hold: leave start asserted across the whole transaction
   task automatic run_txn(input int dv, input int ln, input logic [31:0] wr,
                          input int mode, input int poke_c, input bit hold);
      int          h, l, t, p, bi, rises;
      logic        prev_clk;
      logic [31:0] exp_rd;
      logic [63:0] m;
      logic        dseq [0:1023];
      logic        e_clk, e_din, e_load, e_busy, e_done;
      logic [31:0] e_rd;

      h = 1 << dv;
      l = (ln == 0 || ln > 32) ? 32 : ln;
      t = (2 * l + 2) * h;
      for (int i = 0; i <= t; i++) begin
         dseq[i] = (mode == 2) ? 1'b1 : 1'($urandom & 1);
      end

      // Readback of high phase k is whatever sr_dout shows in its last cycle.
      exp_rd = '0;
      if (mode == 1) begin
         m      = (64'd1 << l) - 64'd1;
         exp_rd = wr & m[31:0];
      end else begin
         for (int k = 0; k < l; k++) begin
            exp_rd[l-1-k] = dseq[h * (2 + 2 * k) - 1];
         end
      end

      loop_mode = (mode == 1);
      div       = dv[3:0];
      len       = ln[5:0];
      wr_data   = wr;
      start     = 1'b1;
      @(posedge clk_in);
      #1;
      if (!hold) start = 1'b0;

      rises    = 0;
      prev_clk = 1'b0;
      for (int c = 0; c <= t; c++) begin
         dout_drv = dseq[c];
         if (c == poke_c) begin
            start   = 1'b1;
            div     = ~div;
            wr_data = ~wr;
            len     = len + 6'd3;
         end else if (c == poke_c + 1 && !hold) begin
            start = 1'b0;
         end

         if (c < t) begin
            p      = c / h;
            bi     = l - 1 - (((p / 2) < (l - 1)) ? (p / 2) : (l - 1));
            e_clk  = ((p % 2) == 1) && (p <= 2 * l - 1);
            e_load = (p == 2 * l + 1);
            e_din  = wr[bi];
            e_busy = 1'b1;
            e_done = 1'b0;
            e_rd   = prev_rd;
         end else begin
            e_clk  = 1'b0;
            e_load = 1'b0;
            e_din  = wr[0];
            e_busy = 1'b0;
            e_done = 1'b1;
            e_rd   = exp_rd;
         end

         chk($sformatf("sr_clk@%0d",  c), 32'(sr_clk),  32'(e_clk));
         chk($sformatf("sr_din@%0d",  c), 32'(sr_din),  32'(e_din));
         chk($sformatf("sr_load@%0d", c), 32'(sr_load), 32'(e_load));
         chk($sformatf("busy@%0d",    c), 32'(busy),    32'(e_busy));
         chk($sformatf("done@%0d",    c), 32'(done),    32'(e_done));
         chk($sformatf("rd_data@%0d", c), rd_data,      e_rd);

         if (sr_clk && !prev_clk) rises++;
         prev_clk = sr_clk;
         if (c < t) begin
            @(posedge clk_in);
            #1;
         end
      end
      chk("sr_clk_rises", 32'(rises), 32'(l));
      prev_rd = exp_rd;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      prev_rd   = '0;
      loop_mode = 1'b0;
      dout_drv  = 1'b0;
      start     = 1'b0;
      div       = '0;
      len       = '0;
      wr_data   = '0;
      rst       = 1'b1;

      // Reset state
      #3 rst = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk_all_zero("reset");
      #2 rst = 1'b1;

      // Loopback, div 0, 8 bits of 0xA5
      run_txn(0, 8, 32'h0000_00A5, 1, -1, 1'b0);
      chk("loop_rd", rd_data, 32'h0000_00A5);

      // Slow clock, readback tied high
      run_txn(3, 4, 32'h0000_000C, 2, -1, 1'b0);
      chk("tied1_rd", rd_data, 32'h0000_000F);

      // Length 0 and out-of-range length both shift the full register
      run_txn(0, 0,  $urandom, 0, -1, 1'b0);
      run_txn(0, 40, $urandom, 0, -1, 1'b0);

      // Conflicting start with changed inputs while busy
      run_txn(1, 6, $urandom, 0, 5, 1'b0);
      run_txn(0, 3, $urandom, 1, 2, 1'b0);

      // Asynchronous reset during the third high phase
      div     = 4'd2;
      len     = 6'd8;
      wr_data = $urandom;
      start   = 1'b1;
      @(posedge clk_in);
      #1;
      start = 1'b0;
      repeat (21) @(posedge clk_in);
      #2;
      chk("pre_rst_sr_clk", 32'(sr_clk), 32'd1);
      rst = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (3) begin
         @(posedge clk_in);
         #1;
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      #2 rst = 1'b1;
      prev_rd = '0;
      run_txn(2, 8, $urandom, 0, -1, 1'b0);

      // Start held high: back-to-back accepts 13 cycles apart
      run_txn(1, 2, $urandom, 0, -1, 1'b1);
      run_txn(1, 2, $urandom, 0, -1, 1'b1);
      run_txn(1, 2, $urandom, 1, -1, 1'b1);
      start = 1'b0;

      // Randomised transactions
      for (int n = 0; n < 8; n++) begin
         run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 40)), $urandom,
                 int'($urandom_range(0, 2)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, 1'b0);
      end

      // Quiet after the last transaction
      repeat (3) begin
         @(posedge clk_in);
         #1;
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_rd",   rd_data,   prev_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
